// File: rtl/jellyvl_synctimer_pkg.sv
// Shared types for the synctimer correction path (sequencer and adjuster).
// Keeps timer/phase typedefs and the sequencer state encoding in one place.
package jellyvl_synctimer_pkg;

    typedef logic        [63:0] t_timer;
    typedef logic        [31:0] t_calc;
    typedef logic signed [31:0] t_phase;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } t_state;

    // Cycles from an accepted sample to its correction strobe.
    localparam int PIPELINE_LATENCY = 2;

endpackage

// File: rtl/jellyvl_synctimer_interval_gate.sv
// Rate limiter for incoming remote samples: a saturating cycle counter since
// the last accepted sample, and a registered drop pulse for rejected ones.
module jellyvl_synctimer_interval_gate #(
    parameter int INTERVAL_WIDTH = 16
) (
    input  logic                      reset,
    input  logic                      clk,
    input  logic [INTERVAL_WIDTH-1:0] param_min_interval,
    input  logic                      s_valid,
    output logic                      accept,
    output logic                      drop
);

    logic [INTERVAL_WIDTH-1:0] cnt_q;
    logic [INTERVAL_WIDTH-1:0] cnt_d;
    logic                      drop_q;
    logic                      drop_d;

    assign accept = s_valid && (cnt_q >= param_min_interval);
    assign drop   = drop_q;

    always_comb begin
        cnt_d  = cnt_q;
        drop_d = s_valid && !accept;
        if (accept) begin
            cnt_d = '0;
        end else if (!(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter resets saturated so the very first sample is always taken.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '1;
            drop_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

endmodule

// File: rtl/jellyvl_synctimer_correct_sequencer.sv
// Correction sequencer: gates remote samples, measures phase error and
// decides between hard override (resync) and normal tracking strobes.
module jellyvl_synctimer_correct_sequencer
    import jellyvl_synctimer_pkg::*;
#(
    parameter int TIMER_WIDTH    = 64,
    parameter int CALC_WIDTH     = 32,
    parameter int PHASE_WIDTH    = 32,
    parameter int COUNT_WIDTH    = 8,
    parameter int INTERVAL_WIDTH = 16
) (
    input  logic                      reset,
    input  logic                      clk,
    input  logic [PHASE_WIDTH-1:0]    param_lock_limit,
    input  logic [PHASE_WIDTH-1:0]    param_unlock_limit,
    input  logic [COUNT_WIDTH-1:0]    param_lock_count,
    input  logic [COUNT_WIDTH-1:0]    param_unlock_count,
    input  logic [INTERVAL_WIDTH-1:0] param_min_interval,
    input  logic [TIMER_WIDTH-1:0]    local_time,
    input  logic [TIMER_WIDTH-1:0]    s_time,
    input  logic                      s_valid,
    output logic                      correct_override,
    output logic [TIMER_WIDTH-1:0]    correct_time,
    output logic                      correct_valid,
    output logic                      locked,
    output logic                      resync,
    output logic                      drop
);

    logic accept;

    jellyvl_synctimer_interval_gate #(
        .INTERVAL_WIDTH (INTERVAL_WIDTH)
    ) u_gate (
        .reset              (reset),
        .clk                (clk),
        .param_min_interval (param_min_interval),
        .s_valid            (s_valid),
        .accept             (accept),
        .drop               (drop)
    );

    // Stage A: phase error magnitude from the low timer bits.
    logic [CALC_WIDTH-1:0]  calc_diff;
    logic [PHASE_WIDTH-1:0] err_bits;
    logic [PHASE_WIDTH-1:0] abs_val;
    logic                   unused_local_hi;

    assign unused_local_hi = ^local_time[TIMER_WIDTH-1:CALC_WIDTH];
    assign calc_diff       = s_time[CALC_WIDTH-1:0] - local_time[CALC_WIDTH-1:0];
    assign err_bits        = calc_diff[PHASE_WIDTH-1:0];

    always_comb begin
        abs_val = err_bits;
        if (err_bits == {1'b1, {(PHASE_WIDTH-1){1'b0}}}) begin
            abs_val = {1'b0, {(PHASE_WIDTH-1){1'b1}}};
        end else if (err_bits[PHASE_WIDTH-1]) begin
            abs_val = ~err_bits + 1'b1;
        end
    end

    logic                   a_valid_q, a_valid_d;
    logic [PHASE_WIDTH-1:0] a_abs_q,   a_abs_d;
    logic [TIMER_WIDTH-1:0] a_time_q,  a_time_d;

    always_comb begin
        a_valid_d = accept;
        a_abs_d   = a_abs_q;
        a_time_d  = a_time_q;
        if (accept) begin
            a_abs_d  = abs_val;
            a_time_d = s_time;
        end
    end

    // Stage B: lock state machine and registered correction outputs.
    t_state                 state_q,    state_d;
    logic [COUNT_WIDTH-1:0] lock_cnt_q, lock_cnt_d;
    logic [COUNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
    logic                   valid_q,    valid_d;
    logic                   override_q, override_d;
    logic                   locked_q,   locked_d;
    logic [TIMER_WIDTH-1:0] time_q,     time_d;

    logic [COUNT_WIDTH-1:0] lock_inc;
    logic [COUNT_WIDTH-1:0] miss_inc;
    logic [COUNT_WIDTH-1:0] lock_need;
    logic [COUNT_WIDTH-1:0] miss_need;
    logic                   out_of_range;
    logic                   in_lock;

    assign lock_inc     = (&lock_cnt_q) ? lock_cnt_q : lock_cnt_q + 1'b1;
    assign miss_inc     = (&miss_cnt_q) ? miss_cnt_q : miss_cnt_q + 1'b1;
    assign lock_need    = (param_lock_count == '0)   ? COUNT_WIDTH'(1) : param_lock_count;
    assign miss_need    = (param_unlock_count == '0) ? COUNT_WIDTH'(1) : param_unlock_count;
    assign out_of_range = (a_abs_q > param_unlock_limit);
    assign in_lock      = (a_abs_q <= param_lock_limit);

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        miss_cnt_d = miss_cnt_q;
        valid_d    = 1'b0;
        override_d = 1'b0;
        time_d     = time_q;
        if (a_valid_q) begin
            time_d = a_time_q + TIMER_WIDTH'(PIPELINE_LATENCY);
            unique case (state_q)
                ST_IDLE: begin
                    valid_d    = 1'b1;
                    override_d = 1'b1;
                    lock_cnt_d = '0;
                    state_d    = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    valid_d = 1'b1;
                    // Unlock test wins even if lock_limit exceeds unlock_limit.
                    if (out_of_range) begin
                        override_d = 1'b1;
                        lock_cnt_d = '0;
                    end else if (in_lock) begin
                        lock_cnt_d = lock_inc;
                        if (lock_inc >= lock_need) begin
                            state_d    = ST_LOCKED;
                            miss_cnt_d = '0;
                        end
                    end else begin
                        lock_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!out_of_range) begin
                        valid_d    = 1'b1;
                        miss_cnt_d = '0;
                    end else begin
                        // Isolated outliers are swallowed rather than fed to the adjuster.
                        miss_cnt_d = miss_inc;
                        if (miss_inc >= miss_need) begin
                            valid_d    = 1'b1;
                            override_d = 1'b1;
                            lock_cnt_d = '0;
                            miss_cnt_d = '0;
                            state_d    = ST_ACQUIRE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_valid_q  <= 1'b0;
            a_abs_q    <= '0;
            a_time_q   <= '0;
            state_q    <= ST_IDLE;
            lock_cnt_q <= '0;
            miss_cnt_q <= '0;
            valid_q    <= 1'b0;
            override_q <= 1'b0;
            locked_q   <= 1'b0;
            time_q     <= '0;
        end else begin
            a_valid_q  <= a_valid_d;
            a_abs_q    <= a_abs_d;
            a_time_q   <= a_time_d;
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            valid_q    <= valid_d;
            override_q <= override_d;
            locked_q   <= locked_d;
            time_q     <= time_d;
        end
    end

    assign correct_valid    = valid_q;
    assign correct_override = override_q;
    assign resync           = override_q;
    assign correct_time     = time_q;
    assign locked           = locked_q;

endmodule

// File: tb/tb_jellyvl_synctimer_correct_sequencer.sv
// Directed bench: a table of single samples with hand-computed strobes, plus
// sequences for back-to-back samples, the interval gate and mid-pipeline reset.
module tb_jellyvl_synctimer_correct_sequencer;

    logic        reset;
    logic        clk;
    logic [31:0] param_lock_limit;
    logic [31:0] param_unlock_limit;
    logic [7:0]  param_lock_count;
    logic [7:0]  param_unlock_count;
    logic [15:0] param_min_interval;
    logic [63:0] local_time;
    logic [63:0] s_time;
    logic        s_valid;
    logic        correct_override;
    logic [63:0] correct_time;
    logic        correct_valid;
    logic        locked;
    logic        resync;
    logic        drop;

    jellyvl_synctimer_correct_sequencer dut (
        .reset              (reset),
        .clk                (clk),
        .param_lock_limit   (param_lock_limit),
        .param_unlock_limit (param_unlock_limit),
        .param_lock_count   (param_lock_count),
        .param_unlock_count (param_unlock_count),
        .param_min_interval (param_min_interval),
        .local_time         (local_time),
        .s_time             (s_time),
        .s_valid            (s_valid),
        .correct_override   (correct_override),
        .correct_time       (correct_time),
        .correct_valid      (correct_valid),
        .locked             (locked),
        .resync             (resync),
        .drop               (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] s_time;
        logic [63:0] local_time;
        logic        exp_valid;
        logic        exp_ovr;
        logic        exp_locked;
        logic [63:0] exp_time;
    } vec_t;

    vec_t vecs[11];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one sample for a cycle and sample outputs two cycles later.
    task automatic apply_sample(input logic [63:0] st, input logic [63:0] lt);
        @(negedge clk);
        s_time     = st;
        local_time = lt;
        s_valid    = 1'b1;
        @(negedge clk);
        s_valid    = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset              = 1'b1;
        s_valid            = 1'b0;
        s_time             = '0;
        local_time         = '0;
        param_lock_limit   = 32'd4;
        param_unlock_limit = 32'd100;
        param_lock_count   = 8'd3;
        param_unlock_count = 8'd2;
        param_min_interval = 16'd0;

        vecs[0]  = '{64'd1000, 64'd0, 1'b1, 1'b1, 1'b0, 64'd1002};
        vecs[1]  = '{64'd102,  64'd100, 1'b1, 1'b0, 1'b0, 64'd104};
        vecs[2]  = '{64'd202,  64'd200, 1'b1, 1'b0, 1'b0, 64'd204};
        vecs[3]  = '{64'd302,  64'd300, 1'b1, 1'b0, 1'b1, 64'd304};
        vecs[4]  = '{64'd900,  64'd400, 1'b0, 1'b0, 1'b1, 64'd0};
        vecs[5]  = '{64'd1001, 64'd1000, 1'b1, 1'b0, 1'b1, 64'd1003};
        vecs[6]  = '{64'd1600, 64'd1100, 1'b0, 1'b0, 1'b1, 64'd0};
        vecs[7]  = '{64'd1700, 64'd1200, 1'b1, 1'b1, 1'b0, 64'd1702};
        vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0, 1'b0, 64'd1};
        vecs[9]  = '{64'h0000_0000_8000_0000, 64'd0, 1'b1, 1'b1, 1'b0, 64'h0000_0000_8000_0002};
        vecs[10] = '{64'd100,  64'd103, 1'b1, 1'b0, 1'b0, 64'd102};

        repeat (3) @(negedge clk);
        check("rst_valid",    {63'd0, correct_valid},    64'd0);
        check("rst_override", {63'd0, correct_override}, 64'd0);
        check("rst_resync",   {63'd0, resync},           64'd0);
        check("rst_locked",   {63'd0, locked},           64'd0);
        check("rst_drop",     {63'd0, drop},             64'd0);
        check("rst_time",     correct_time,              64'd0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            apply_sample(vecs[i].s_time, vecs[i].local_time);
            $display("vec %0d: s_time=%0h local=%0h valid=%0b ovr=%0b locked=%0b time=%0h",
                     i, vecs[i].s_time, vecs[i].local_time, correct_valid,
                     correct_override, locked, correct_time);
            check($sformatf("vec%0d_valid", i),  {63'd0, correct_valid},    {63'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_ovr", i),    {63'd0, correct_override}, {63'd0, vecs[i].exp_ovr});
            check($sformatf("vec%0d_resync", i), {63'd0, resync},           {63'd0, vecs[i].exp_ovr});
            check($sformatf("vec%0d_locked", i), {63'd0, locked},           {63'd0, vecs[i].exp_locked});
            check($sformatf("vec%0d_drop", i),   {63'd0, drop},             64'd0);
            if (vecs[i].exp_valid) begin
                check($sformatf("vec%0d_time", i), correct_time, vecs[i].exp_time);
            end
        end

        // Back-to-back samples in ACQUIRE (lock_cnt=1): strobes on consecutive cycles.
        @(negedge clk);
        s_time = 64'd5002; local_time = 64'd5000; s_valid = 1'b1;
        @(negedge clk);
        s_time = 64'd6002; local_time = 64'd6000;
        @(negedge clk);
        s_valid = 1'b0;
        $display("b2b first: valid=%0b ovr=%0b locked=%0b time=%0h", correct_valid, correct_override, locked, correct_time);
        check("b2b0_valid",  {63'd0, correct_valid},    64'd1);
        check("b2b0_ovr",    {63'd0, correct_override}, 64'd0);
        check("b2b0_locked", {63'd0, locked},           64'd0);
        check("b2b0_time",   correct_time,              64'd5004);
        @(negedge clk);
        $display("b2b second: valid=%0b ovr=%0b locked=%0b time=%0h", correct_valid, correct_override, locked, correct_time);
        check("b2b1_valid",  {63'd0, correct_valid},    64'd1);
        check("b2b1_locked", {63'd0, locked},           64'd1);
        check("b2b1_time",   correct_time,              64'd6004);

        // Interval gate: samples at cycles 0, 5, 12 with min_interval=10.
        param_min_interval = 16'd10;
        repeat (20) @(negedge clk);
        for (int c = 0; c < 17; c++) begin
            if (c > 0) @(negedge clk);
            $display("gate cycle %0d: valid=%0b drop=%0b", c, correct_valid, drop);
            check($sformatf("gate%0d_valid", c), {63'd0, correct_valid}, {63'd0, (c == 2 || c == 14)});
            check($sformatf("gate%0d_drop", c),  {63'd0, drop},          {63'd0, (c == 6)});
            local_time = 64'(c) * 64'd1000;
            s_time     = local_time + 64'd2;
            s_valid    = (c == 0 || c == 5 || c == 12);
        end
        s_valid = 1'b0;
        param_min_interval = 16'd0;
        repeat (2) @(negedge clk);

        // Reset one cycle after an accepted sample kills the in-flight strobe.
        check("pre_rst_locked", {63'd0, locked}, 64'd1);
        @(negedge clk);
        s_time = 64'd7002; local_time = 64'd7000; s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        $display("mid reset: valid=%0b locked=%0b", correct_valid, locked);
        check("mrst_valid0",  {63'd0, correct_valid}, 64'd0);
        check("mrst_locked",  {63'd0, locked},        64'd0);
        @(negedge clk);
        check("mrst_valid1",  {63'd0, correct_valid}, 64'd0);
        apply_sample(64'd8000, 64'd8000);
        $display("post reset: valid=%0b ovr=%0b time=%0h", correct_valid, correct_override, correct_time);
        check("prst_valid", {63'd0, correct_valid},    64'd1);
        check("prst_ovr",   {63'd0, correct_override}, 64'd1);
        check("prst_time",  correct_time,              64'd8002);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
